// File: rtl/median_filter_axil_pkg.sv
// Shared types and constants for the median filter AXI4-Lite register bank.
package median_filter_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [3:0] REG0_OFS = 4'h0;
  localparam logic [3:0] REG1_OFS = 4'h4;
  localparam logic [3:0] REG2_OFS = 4'h8;
  localparam logic [3:0] REG3_OFS = 4'hC;

  typedef logic [31:0] reg_t;

  localparam reg_t SLVERR_RDATA = 32'hDEADBEEF;

  // Word-select bits [3:2] mapped to a register index.
  function automatic logic [1:0] reg_sel(input logic [1:0] word);
    case ({word, 2'b00})
      REG0_OFS: reg_sel = 2'd0;
      REG1_OFS: reg_sel = 2'd1;
      REG2_OFS: reg_sel = 2'd2;
      REG3_OFS: reg_sel = 2'd3;
      default:  reg_sel = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/median_filter_axil_strb_merge.sv
// Per-byte merge of new write data into the old register value under WSTRB.
module median_filter_axil_strb_merge
  import median_filter_axil_pkg::*;
(
  input  reg_t       old_i,
  input  reg_t       new_i,
  input  logic [3:0] strb_i,
  output reg_t       merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int b = 0; b < 4; b++) begin
      if (strb_i[b]) merged_o[8*b +: 8] = new_i[8*b +: 8];
    end
  end

endmodule

// File: rtl/median_filter_axil_regs.sv
// AXI4-Lite slave with four 32-bit configuration registers for the median filter.
// Define MEDIAN_FILTER_AXIL_SLVERR_EN to flag addresses above 0xF with SLVERR.
module median_filter_axil_regs
  import median_filter_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [31:0]                     reg0_o,
  output logic [31:0]                     reg1_o,
  output logic [31:0]                     reg2_o,
  output logic [31:0]                     reg3_o
);

  logic                          aw_full_q, aw_full_d;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                          awready_q, awready_d;
  logic                          w_full_q, w_full_d;
  reg_t                          w_data_q, w_data_d;
  logic [3:0]                    w_strb_q, w_strb_d;
  logic                          wready_q, wready_d;
  logic                          bvalid_q, bvalid_d;
  logic [1:0]                    bresp_q, bresp_d;
  logic                          ar_full_q, ar_full_d;
  logic                          ar_err_q, ar_err_d;
  reg_t                          ar_data_q, ar_data_d;
  logic                          arready_q, arready_d;
  logic                          rvalid_q, rvalid_d;
  reg_t                          rdata_q, rdata_d;
  logic [1:0]                    rresp_q, rresp_d;
  reg_t                          regs_q [4];
  reg_t                          regs_d [4];

  logic       aw_err, ar_err_in;
  logic [1:0] aw_idx;
  reg_t       merged;
  logic       unused_ok;

`ifdef MEDIAN_FILTER_AXIL_SLVERR_EN
  assign aw_err    = (aw_addr_q >> 4) != '0;
  assign ar_err_in = (S_AXI_ARADDR >> 4) != '0;
`else
  assign aw_err    = 1'b0;
  assign ar_err_in = 1'b0;
`endif

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, aw_addr_q, S_AXI_ARADDR};
  assign aw_idx    = reg_sel(aw_addr_q[3:2]);

  median_filter_axil_strb_merge u_strb_merge (
    .old_i    (regs_q[aw_idx]),
    .new_i    (w_data_q),
    .strb_i   (w_strb_q),
    .merged_o (merged)
  );

  always_comb begin
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    ar_full_d = ar_full_q;
    ar_err_d  = ar_err_q;
    ar_data_d = ar_data_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    regs_d    = regs_q;

    if (awready_q && S_AXI_AWVALID) begin
      aw_full_d = 1'b1;
      aw_addr_d = S_AXI_AWADDR;
    end
    if (wready_q && S_AXI_WVALID) begin
      w_full_d = 1'b1;
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
    end
    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
    if (aw_full_q && w_full_q && !bvalid_q) begin
      if (!aw_err) regs_d[aw_idx] = merged;
      bvalid_d  = 1'b1;
      bresp_d   = aw_err ? RESP_SLVERR : RESP_OKAY;
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end
    awready_d = !aw_full_d && !bvalid_d;
    wready_d  = !w_full_d && !bvalid_d;

    // Read data is snapshotted at the AR handshake so a write landing later returns the old value.
    if (arready_q && S_AXI_ARVALID) begin
      ar_full_d = 1'b1;
      ar_err_d  = ar_err_in;
      ar_data_d = ar_err_in ? SLVERR_RDATA : regs_q[reg_sel(S_AXI_ARADDR[3:2])];
    end
    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    if (ar_full_q && !rvalid_q) begin
      rvalid_d  = 1'b1;
      rdata_d   = ar_data_q;
      rresp_d   = ar_err_q ? RESP_SLVERR : RESP_OKAY;
      ar_full_d = 1'b0;
    end
    arready_d = !ar_full_d && !rvalid_d;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      awready_q <= 1'b0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      ar_full_q <= 1'b0;
      ar_err_q  <= 1'b0;
      ar_data_q <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      awready_q <= awready_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      ar_full_q <= ar_full_d;
      ar_err_q  <= ar_err_d;
      ar_data_q <= ar_data_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      regs_q    <= regs_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign reg0_o        = regs_q[0];
  assign reg1_o        = regs_q[1];
  assign reg2_o        = regs_q[2];
  assign reg3_o        = regs_q[3];

endmodule

// File: tb/tb_median_filter_axil_regs.sv
// Randomized self-checking bench for median_filter_axil_regs against a register-array model.
module tb_median_filter_axil_regs;

  localparam int AW = 5;
`ifdef MEDIAN_FILTER_AXIL_SLVERR_EN
  localparam bit SLVERR_ON = 1'b1;
`else
  localparam bit SLVERR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic [31:0]   reg0, reg1, reg2, reg3;

  always #5 clk = ~clk;

  median_filter_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(AW)) dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg0_o(reg0), .reg1_o(reg1), .reg2_o(reg2), .reg3_o(reg3)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] mdl [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic oor(input logic [AW-1:0] a);
    return SLVERR_ON && (a >= AW'(16));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] mask;
    mask = 32'h0;
    for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8 * b));
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_reg0"}, reg0, mdl[0]);
    chk({tag, "_reg1"}, reg1, mdl[1]);
    chk({tag, "_reg2"}, reg2, mdl[2]);
    chk({tag, "_reg3"}, reg3, mdl[3]);
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
    int cyc;
    bit aw_done, w_done, aw_hs, w_hs;
    aw_done = 0; w_done = 0; cyc = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    while (!(aw_done && w_done) && cyc < 40) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      if (aw_hs) begin aw_done = 1; chk("awready_drop", 32'(awready), 0); end
      if (w_hs)  begin w_done = 1;  chk("wready_drop", 32'(wready), 0); end
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    chk("wr_handshake_timeout", 32'(aw_done && w_done), 1);
    if (!(aw_done && w_done)) return;
    chk("bvalid_before_commit", 32'(bvalid), 0);
    if (!oor(addr)) mdl[addr[3:2]] = merge(mdl[addr[3:2]], data, strb);
    tick();
    chk("bvalid_commit", 32'(bvalid), 1);
    chk("bresp", 32'(bresp), oor(addr) ? 2 : 0);
    chk_regs("wr");
    for (int i = 0; i < b_dly; i++) begin
      tick();
      chk("bvalid_hold", 32'(bvalid), 1);
      chk("awready_wait", 32'(awready), 0);
      chk("wready_wait", 32'(wready), 0);
    end
    bready = 1;
    tick();
    bready = 0;
    chk("bvalid_drop", 32'(bvalid), 0);
    chk("awready_back", 32'(awready), 1);
    chk("wready_back", 32'(wready), 1);
  endtask

  task automatic rd_resp_phase(input logic [31:0] exp_d, input logic [1:0] exp_r, input int r_dly);
    chk("rvalid_rise", 32'(rvalid), 1);
    chk("rdata", rdata, exp_d);
    chk("rresp", 32'(rresp), 32'(exp_r));
    for (int i = 0; i < r_dly; i++) begin
      tick();
      chk("rvalid_hold", 32'(rvalid), 1);
      chk("rdata_hold", rdata, exp_d);
      chk("arready_wait", 32'(arready), 0);
    end
    rready = 1;
    tick();
    rready = 0;
    chk("rvalid_drop", 32'(rvalid), 0);
    chk("arready_back", 32'(arready), 1);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int r_dly);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    int cyc;
    bit hs;
    exp_d = oor(addr) ? 32'hDEADBEEF : mdl[addr[3:2]];
    exp_r = oor(addr) ? 2'b10 : 2'b00;
    araddr = addr; arvalid = 1; hs = 0; cyc = 0;
    while (!hs && cyc < 40) begin
      hs = arready;
      tick();
      cyc++;
    end
    arvalid = 0;
    chk("rd_handshake_timeout", 32'(hs), 1);
    if (!hs) return;
    chk("arready_drop", 32'(arready), 0);
    chk("rvalid_before", 32'(rvalid), 0);
    tick();
    rd_resp_phase(exp_d, exp_r, r_dly);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0]   old_v;
    logic [AW-1:0] ra;
    rst = 1; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    wdata = '0; wstrb = '0;
    for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
    repeat (3) tick();
    chk("rst_awready", 32'(awready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_resp", 32'({bresp, rresp}), 0);
    chk_regs("rst");
    rst = 0;
    chk("post_rst1_ready", 32'({awready, wready, arready}), 0);
    tick();
    chk("post_rst2_ready", 32'({awready, wready, arready}), 32'h7);

    for (int i = 0; i < 4; i++) axi_write(AW'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(AW'(4 * i), 0);
    chk("plan_regs", {reg0[7:0], reg1[7:0], reg2[7:0], reg3[7:0]}, 32'h01020304);

    axi_write(5'h04, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    axi_write(5'h04, 32'h0000A5A5, 4'b0011, 0, 0, 0);
    axi_read(5'h04, 1);
    chk("strb_merge_reg1", reg1, 32'hFFFFA5A5);

    axi_write(5'h08, 32'h0BADF00D, 4'hF, 3, 0, 0);
    axi_write(5'h00, 32'hCAFE0001, 4'hF, 0, 0, 5);
    axi_write(5'h08, 32'h12345678, 4'h0, 1, 0, 0);
    chk("strb0_reg2", reg2, 32'h0BADF00D);

    // Write to 0xC commits on the same edge as the AR handshake to 0xC.
    awaddr = 5'h0C; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    chk("same_edge_ready", 32'({awready, wready}), 32'h3);
    tick();
    awvalid = 0; wvalid = 0; araddr = 5'h0C; arvalid = 1;
    chk("same_edge_arready", 32'(arready), 1);
    old_v = mdl[3];
    mdl[3] = 32'h55;
    tick();
    arvalid = 0;
    chk("same_edge_bvalid", 32'(bvalid), 1);
    chk("same_edge_reg3", reg3, 32'h55);
    tick();
    bready = 0;
    chk("same_edge_bdrop", 32'(bvalid), 0);
    rd_resp_phase(old_v, 2'b00, 4);
    chk("same_edge_old", old_v, 32'h4);

    // Reset while AW is pending and W never arrives.
    awaddr = 5'h04; awvalid = 1;
    tick();
    chk("abort_aw_taken", 32'(awready), 0);
    rst = 1;
    tick();
    rst = 0; awvalid = 0;
    for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
    chk("abort_ready_low", 32'({awready, wready, arready}), 0);
    chk("abort_bvalid", 32'(bvalid), 0);
    chk_regs("abort");
    tick();
    chk("abort_ready_back", 32'({awready, wready, arready}), 32'h7);
    repeat (3) begin
      tick();
      chk("abort_no_b", 32'(bvalid), 0);
    end

    axi_write(5'h14, 32'h87654321, 4'hF, 0, 0, 0);
    axi_read(5'h10, 0);
    axi_read(5'h14, 2);

    for (int k = 0; k < 30; k++) begin
      ra = AW'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1)
        axi_write(ra, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      else
        axi_read(ra, int'($urandom_range(0, 2)));
    end
    chk_regs("final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
